qseq: RTL and testbench
=======================

QSEQ -- requirements
Module: qseq

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request a multiply or divide sequence; sampled only in IDLE
- op_div  in  1  captured with start; 0 = multiply, 1 = divide
- count  in  6  captured with start; number of steps; 0 means 32, values above 32 are treated as 32
- step_en  in  1  microcycle advance strobe (ALU state); a STEP cycle is taken only when this is 1
- q0  in  1  current Q register bit 0 (multiply decision)
- alu_sign  in  1  sign of the current ALU result (divide decision)
- abort  in  1  synchronous cancel
- qs1, qs0  out  1 each  Q shift select: 00 hold, 01 shift left, 10 shift right, 11 load
- alu_add  out  1  ALU performs add this cycle
- alu_sub  out  1  ALU performs subtract this cycle
- q_in  out  1  bit shifted into Q on a left shift
- busy  out  1  a sequence is in progress
- done  out  1  single-cycle completion pulse
- remaining  out  6  steps still to execute

Function
REQ-002 The FSM SHALL have the states IDLE, INIT, STEP and DONE, encoded in registers with no latches.
REQ-003 IDLE: busy=0 and qs=00; when start=1 and abort=0, it SHALL capture op_div and the normalised count (1..32) and go to INIT on the next edge.
REQ-004 INIT lasts exactly one cycle regardless of step_en: qs=11, busy=1, the sign register is cleared to 0, remaining is loaded with the normalised count, then the FSM goes to STEP.
REQ-005 STEP with step_en=0: qs=00, alu_add=0, alu_sub=0, and the state and counter SHALL hold.
REQ-006 STEP with step_en=1, multiply: qs=10 (shift right) and alu_add=q0.
REQ-007 STEP with step_en=1, divide: qs=01 (shift left); alu_sub=~sign_r and alu_add=sign_r; q_in=~alu_sign; sign_r<=alu_sign at the edge.
REQ-008 Every STEP cycle with step_en=1 SHALL decrement remaining by 1 (6-bit, never wraps below 0); when remaining==1 at the edge, the next state is DONE.
REQ-009 DONE lasts exactly one cycle: done=1, busy=1, qs=00, remaining=0; the next state is IDLE.
REQ-010 A start seen in INIT, STEP or DONE SHALL be ignored and SHALL NOT be queued; a start in the IDLE cycle right after DONE SHALL be accepted.
REQ-011 abort=1 in any state SHALL force IDLE on the next edge with remaining=0 and no done pulse; abort has priority over start and over step completion in the same cycle.
REQ-012 All outputs SHALL be decoded from registered state and registered counters plus the current q0, alu_sign and step_en, with no other combinational input-to-output paths.
REQ-013 alu_add and alu_sub SHALL never both be 1; q_in=0 outside divide STEP cycles with step_en=1.
REQ-014 Latency from start to done SHALL be 2 + (number of step_en=1 STEP cycles) + the stall cycles; with step_en held at 1 and count=N, done is asserted N+2 cycles after the start edge.

Reset
REQ-015 reset=0 SHALL immediately and asynchronously force IDLE, remaining=0, sign_r=0, captured op_div=0, and all outputs to 0 (qs=00, busy=0, done=0).
REQ-016 Deassertion of reset SHALL take effect on the next clock edge; a start in the first cycle after deassertion SHALL be accepted.
REQ-017 Reset asserted mid-sequence SHALL abandon the sequence with no done pulse.

Verification
REQ-018 The bench SHALL cover at least these directed scenarios:
- Multiply, count=4, step_en=1, q0 pattern 1,0,1,1: INIT qs=11; four cycles qs=10 with alu_add=1,0,1,1; done at cycle 6; remaining 4,3,2,1,0.
- Divide, count=3, alu_sign pattern 0,1,0: alu_sub=1,1,0 and alu_add=0,0,1; q_in=1,0,1; qs=01 each step.
- count=0 with step_en=1: exactly 32 STEP cycles, done 34 cycles after start; count=40 behaves identically.
- Multiply count=2 with step_en=1,0,0,1: qs=10,00,00,10; done 6 cycles after start; remaining holds during the stalls.
- abort on the second STEP cycle, with start=1 in the same cycle: IDLE next cycle, busy=0, no done, start not accepted.
- reset pulled low asynchronously mid-STEP (between edges): outputs go to 0 immediately; after release, start with count=1 gives done 3 cycles later.

Source files
------------

// File: rtl/qseq_if.sv
// Sequencer-to-datapath bundle for the multiply/divide microsequencer.
// All signals are level-sampled on the rising clock edge; no valid/ready handshake is involved.
interface qseq_if;
  logic       start;
  logic       op_div;
  logic [5:0] count;
  logic       step_en;
  logic       q0;
  logic       alu_sign;
  logic       abort;
  logic       qs1;
  logic       qs0;
  logic       alu_add;
  logic       alu_sub;
  logic       q_in;
  logic       busy;
  logic       done;
  logic [5:0] remaining;
  logic [1:0] state_dbg;

  modport master (
    output start, op_div, count, step_en, q0, alu_sign, abort,
    input  qs1, qs0, alu_add, alu_sub, q_in, busy, done, remaining, state_dbg
  );

  modport slave (
    input  start, op_div, count, step_en, q0, alu_sign, abort,
    output qs1, qs0, alu_add, alu_sub, q_in, busy, done, remaining, state_dbg
  );
endinterface

// File: rtl/qseq.sv
// Shift-and-add multiply / non-restoring divide microsequencer driving the Q-register
// shift select and ALU add/subtract controls.
module qseq (
  input  logic   clk,
  input  logic   reset,
  qseq_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state_r, state_nx;
  logic [5:0] remaining_r, remaining_nx;
  logic       sign_r, sign_nx;
  logic       div_r, div_nx;
  logic [5:0] norm_count;
  logic [1:0] qs;
  logic       alu_add, alu_sub, q_in, busy, done;

  // Zero and anything beyond 32 both mean a full 32-step sequence.
  always_comb begin
    norm_count = bus.count;
    if (bus.count == 6'd0 || bus.count > 6'd32) norm_count = 6'd32;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      remaining_r <= 6'd0;
      sign_r      <= 1'b0;
      div_r       <= 1'b0;
    end else begin
      state_r     <= state_nx;
      remaining_r <= remaining_nx;
      sign_r      <= sign_nx;
      div_r       <= div_nx;
    end
  end

  always_comb begin
    state_nx     = state_r;
    remaining_nx = remaining_r;
    sign_nx      = sign_r;
    div_nx       = div_r;
    qs           = 2'b00;
    alu_add      = 1'b0;
    alu_sub      = 1'b0;
    q_in         = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          div_nx       = bus.op_div;
          remaining_nx = norm_count;
          state_nx     = INIT;
        end
      end
      INIT: begin
        qs       = 2'b11;
        busy     = 1'b1;
        sign_nx  = 1'b0;
        state_nx = STEP;
      end
      STEP: begin
        busy = 1'b1;
        if (bus.step_en) begin
          if (div_r) begin
            // Non-restoring: the previous result's sign picks add vs subtract.
            qs      = 2'b01;
            alu_sub = ~sign_r;
            alu_add = sign_r;
            q_in    = ~bus.alu_sign;
            sign_nx = bus.alu_sign;
          end else begin
            qs      = 2'b10;
            alu_add = bus.q0;
          end
          if (remaining_r != 6'd0) remaining_nx = remaining_r - 6'd1;
          if (remaining_r <= 6'd1) state_nx = DONE;
        end
      end
      DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        remaining_nx = 6'd0;
        state_nx     = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Abort only redirects the next state; this cycle's decoded outputs stand.
    if (bus.abort) begin
      state_nx     = IDLE;
      remaining_nx = 6'd0;
      sign_nx      = sign_r;
      div_nx       = div_r;
    end
  end

  assign bus.qs1       = qs[1];
  assign bus.qs0       = qs[0];
  assign bus.alu_add   = alu_add;
  assign bus.alu_sub   = alu_sub;
  assign bus.q_in      = q_in;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.remaining = remaining_r;
  assign bus.state_dbg = state_r;
endmodule

// File: tb/tb_qseq.sv
// Directed bench for qseq: literal per-cycle vectors plus a cycle-level reference model.
module tb_qseq;
  logic clk   = 1'b0;
  logic reset = 1'b0;

  qseq_if bus();

  qseq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  string tag = "reset_state";
  logic [12:0] exp_q[$];

  // Reference model: a sequence is running, its first cycle is the load cycle,
  // its last cycle is the completion cycle; steps_left counts accepted steps.
  bit m_run, m_init, m_done, m_div, m_sign;
  int m_left;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_run = 0; m_init = 0; m_done = 0; m_div = 0; m_sign = 0; m_left = 0;
    end else if (bus.abort) begin
      m_run = 0; m_init = 0; m_done = 0; m_left = 0;
    end else if (m_done) begin
      m_done = 0; m_run = 0;
    end else if (m_init) begin
      m_init = 0; m_sign = 0;
    end else if (m_run) begin
      if (bus.step_en) begin
        if (m_div) m_sign = bus.alu_sign;
        m_left = m_left - 1;
        if (m_left == 0) m_done = 1;
      end
    end else if (bus.start) begin
      m_run  = 1;
      m_init = 1;
      m_div  = bus.op_div;
      m_left = (bus.count == 0 || bus.count > 32) ? 32 : int'(bus.count);
    end
  end

  function automatic logic [12:0] w(input logic b, input logic d, input logic [1:0] qs,
                                    input logic a, input logic s, input logic qi,
                                    input logic [5:0] r);
    return {b, d, qs, a, s, qi, r};
  endfunction

  function automatic logic [12:0] dut_word();
    return {bus.busy, bus.done, bus.qs1, bus.qs0, bus.alu_add, bus.alu_sub, bus.q_in, bus.remaining};
  endfunction

  function automatic logic [12:0] model_word();
    logic [1:0] qs;
    logic a, s, qi;
    qs = 2'b00; a = 0; s = 0; qi = 0;
    if (m_init) qs = 2'b11;
    else if (m_run && !m_done && bus.step_en) begin
      if (m_div) begin
        qs = 2'b01; s = !m_sign; a = m_sign; qi = !bus.alu_sign;
      end else begin
        qs = 2'b10; a = bus.q0;
      end
    end
    return w(m_run, m_done, qs, a, s, qi, 6'(m_left));
  endfunction

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s [%s] t=%0t: got %b, expected %b (busy,done,qs,add,sub,q_in,remaining)",
               name, tag, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    check("model", dut_word(), model_word());
    if (exp_q.size() > 0) check("vector", dut_word(), exp_q.pop_front());
  end

  task automatic apply(input logic st, input logic dv, input logic [5:0] cn, input logic se,
                       input logic q, input logic sg, input logic ab, input logic [12:0] e);
    @(posedge clk); #1;
    bus.start = st; bus.op_div = dv; bus.count = cn; bus.step_en = se;
    bus.q0 = q; bus.alu_sign = sg; bus.abort = ab;
    exp_q.push_back(e);
  endtask

  logic [12:0] idle_w;
  logic [5:0]  big_cnt[2];

  initial begin
    idle_w = w(0, 0, 2'b00, 0, 0, 0, 6'd0);
    bus.start = 0; bus.op_div = 0; bus.count = 0; bus.step_en = 0;
    bus.q0 = 0; bus.alu_sign = 0; bus.abort = 0;
    exp_q.push_back(idle_w);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;

    tag = "mul4";
    apply(1, 0, 6'd4, 1, 0, 0, 0, idle_w);
    apply(0, 0, 6'd0, 1, 0, 0, 0, w(1, 0, 2'b11, 0, 0, 0, 6'd4));
    apply(0, 0, 6'd0, 1, 1, 0, 0, w(1, 0, 2'b10, 1, 0, 0, 6'd4));
    apply(0, 0, 6'd0, 1, 0, 0, 0, w(1, 0, 2'b10, 0, 0, 0, 6'd3));
    apply(0, 0, 6'd0, 1, 1, 0, 0, w(1, 0, 2'b10, 1, 0, 0, 6'd2));
    apply(0, 0, 6'd0, 1, 1, 0, 0, w(1, 0, 2'b10, 1, 0, 0, 6'd1));
    apply(0, 0, 6'd0, 1, 0, 0, 0, w(1, 1, 2'b00, 0, 0, 0, 6'd0));
    apply(0, 0, 6'd0, 1, 0, 0, 0, idle_w);

    tag = "div3";
    apply(1, 1, 6'd3, 1, 0, 0, 0, idle_w);
    apply(1, 0, 6'd5, 1, 0, 0, 0, w(1, 0, 2'b11, 0, 0, 0, 6'd3));
    apply(1, 0, 6'd5, 1, 0, 0, 0, w(1, 0, 2'b01, 0, 1, 1, 6'd3));
    apply(0, 0, 6'd0, 1, 0, 1, 0, w(1, 0, 2'b01, 0, 1, 0, 6'd2));
    apply(0, 0, 6'd0, 1, 0, 0, 0, w(1, 0, 2'b01, 1, 0, 1, 6'd1));
    apply(1, 0, 6'd2, 1, 0, 0, 0, w(1, 1, 2'b00, 0, 0, 0, 6'd0));

    tag = "mul2_stall";
    apply(1, 0, 6'd2, 1, 0, 0, 0, idle_w);
    apply(0, 0, 6'd0, 1, 1, 0, 0, w(1, 0, 2'b11, 0, 0, 0, 6'd2));
    apply(0, 0, 6'd0, 1, 1, 0, 0, w(1, 0, 2'b10, 1, 0, 0, 6'd2));
    apply(0, 0, 6'd0, 0, 1, 0, 0, w(1, 0, 2'b00, 0, 0, 0, 6'd1));
    apply(0, 0, 6'd0, 0, 1, 0, 0, w(1, 0, 2'b00, 0, 0, 0, 6'd1));
    apply(0, 0, 6'd0, 1, 0, 0, 0, w(1, 0, 2'b10, 0, 0, 0, 6'd1));
    apply(0, 0, 6'd0, 1, 0, 0, 0, w(1, 1, 2'b00, 0, 0, 0, 6'd0));
    apply(0, 0, 6'd0, 1, 0, 0, 0, idle_w);

    big_cnt[0] = 6'd0;
    big_cnt[1] = 6'd40;
    for (int k = 0; k < 2; k++) begin
      tag = (k == 0) ? "count0" : "count40";
      apply(1, 0, big_cnt[k], 1, 0, 0, 0, idle_w);
      apply(0, 0, 6'd0, 1, 0, 0, 0, w(1, 0, 2'b11, 0, 0, 0, 6'd32));
      for (int i = 0; i < 32; i++)
        apply(0, 0, 6'd0, 1, i[0], 0, 0, w(1, 0, 2'b10, i[0], 0, 0, 6'(32 - i)));
      apply(0, 0, 6'd0, 1, 0, 0, 0, w(1, 1, 2'b00, 0, 0, 0, 6'd0));
      apply(0, 0, 6'd0, 1, 0, 0, 0, idle_w);
    end

    tag = "abort";
    apply(1, 1, 6'd5, 1, 0, 0, 0, idle_w);
    apply(0, 0, 6'd0, 1, 0, 1, 0, w(1, 0, 2'b11, 0, 0, 0, 6'd5));
    apply(0, 0, 6'd0, 1, 0, 1, 0, w(1, 0, 2'b01, 0, 1, 0, 6'd5));
    apply(1, 0, 6'd3, 1, 0, 0, 1, w(1, 0, 2'b01, 1, 0, 1, 6'd4));
    apply(0, 0, 6'd0, 1, 0, 0, 0, idle_w);
    apply(0, 0, 6'd0, 1, 0, 0, 0, idle_w);

    tag = "sign_clear";
    apply(1, 1, 6'd1, 1, 0, 0, 0, idle_w);
    apply(0, 0, 6'd0, 1, 0, 0, 0, w(1, 0, 2'b11, 0, 0, 0, 6'd1));
    apply(0, 0, 6'd0, 1, 0, 0, 0, w(1, 0, 2'b01, 0, 1, 1, 6'd1));
    apply(0, 0, 6'd0, 1, 0, 0, 0, w(1, 1, 2'b00, 0, 0, 0, 6'd0));
    apply(0, 0, 6'd0, 1, 0, 0, 0, idle_w);

    tag = "async_reset";
    apply(1, 0, 6'd3, 1, 0, 0, 0, idle_w);
    apply(0, 0, 6'd0, 1, 1, 0, 0, w(1, 0, 2'b11, 0, 0, 0, 6'd3));
    apply(0, 0, 6'd0, 1, 1, 0, 0, w(1, 0, 2'b10, 1, 0, 0, 6'd3));
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("async_reset", dut_word(), idle_w);
    @(posedge clk); #1;
    reset = 1'b1;
    bus.start = 1; bus.op_div = 0; bus.count = 6'd1; bus.step_en = 1; bus.q0 = 0;
    exp_q.push_back(idle_w);
    apply(0, 0, 6'd0, 1, 0, 0, 0, w(1, 0, 2'b11, 0, 0, 0, 6'd1));
    apply(0, 0, 6'd0, 1, 1, 0, 0, w(1, 0, 2'b10, 1, 0, 0, 6'd1));
    apply(0, 0, 6'd0, 1, 0, 0, 0, w(1, 1, 2'b00, 0, 0, 0, 6'd0));
    apply(0, 0, 6'd0, 1, 0, 0, 0, idle_w);

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL exp_q_drain: got %0d pending vectors, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
